// File: rtl/fe_fifo_reader.sv
// Front-end FIFO reader: pops timestamped entries and serializes them into a
// ready/valid byte stream. Define FE_READER_STATS_EN to build the statistics counters.
`timescale 1ns/1ps

module fe_fifo_reader #(
    parameter int pCOUNT_WIDTH = 24
) (
    input  logic                    cwusb_clk,
    input  logic                    reset_i,
    input  logic                    I_fifo_empty,
    output logic                    O_fifo_rd,
    input  logic [1:0]              I_fifo_command,
    input  logic [15:0]             I_fifo_time,
    input  logic [7:0]              I_fifo_data,
    input  logic                    I_flush,
    input  logic                    I_timestamps_disable,
    output logic [7:0]              O_byte,
    output logic                    O_byte_valid,
    input  logic                    I_byte_ready,
    output logic                    O_idle,
    output logic [pCOUNT_WIDTH-1:0] O_bytes_sent,
    output logic [pCOUNT_WIDTH-1:0] O_entries_read
);

    // Command encodings shared with the front-end FIFO writer.
    localparam logic [1:0] FE_FIFO_CMD_DATA = 2'b00;
    localparam logic [1:0] FE_FIFO_CMD_TIME = 2'b10;

    localparam logic [2:0] ST_IDLE = 3'd0;
    localparam logic [2:0] ST_LOAD = 3'd1;
    localparam logic [2:0] ST_B0   = 3'd2;
    localparam logic [2:0] ST_B1   = 3'd3;
    localparam logic [2:0] ST_B2   = 3'd4;

    logic [2:0]  state, state_nxt;
    logic [1:0]  cmd_q;
    logic [15:0] time_q;
    logic [7:0]  data_q;
    logic        xfer;

    assign O_idle       = (state == ST_IDLE);
    assign O_byte_valid = (state == ST_B0) || (state == ST_B1) || (state == ST_B2);
    assign O_fifo_rd    = O_idle && !I_fifo_empty && !I_flush && !reset_i;
    assign xfer         = O_byte_valid && I_byte_ready;

    always_comb begin
        // NOTE: default first so every path assigns state_nxt and no latch is inferred.
        state_nxt = state;
        case (state)
            ST_IDLE: if (O_fifo_rd) state_nxt = ST_LOAD;
            ST_LOAD: begin
                if (I_fifo_command == FE_FIFO_CMD_TIME && I_timestamps_disable)
                    state_nxt = ST_IDLE;
                else
                    state_nxt = ST_B0;
            end
            ST_B0: begin
                if (xfer) begin
                    if (cmd_q == FE_FIFO_CMD_DATA || cmd_q == FE_FIFO_CMD_TIME)
                        state_nxt = ST_B1;
                    else
                        state_nxt = ST_IDLE;
                end
            end
            ST_B1: begin
                if (xfer)
                    state_nxt = (cmd_q == FE_FIFO_CMD_TIME) ? ST_B2 : ST_IDLE;
            end
            ST_B2:   if (xfer) state_nxt = ST_IDLE;
            default: state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge cwusb_clk) begin
        if (reset_i || I_flush)
            state <= ST_IDLE;
        else
            state <= state_nxt;
    end

    // NOTE: entry registers are not reset; they are only observed after LOAD refills them.
    always_ff @(posedge cwusb_clk) begin
        if (state == ST_LOAD) begin
            cmd_q  <= I_fifo_command;
            time_q <= I_fifo_time;
            data_q <= I_fifo_data;
        end
    end

    always_comb begin
        O_byte = 8'h00;
        case (state)
            ST_B0: begin
                case (cmd_q)
                    FE_FIFO_CMD_DATA: O_byte = {time_q[5:0], cmd_q};
                    FE_FIFO_CMD_TIME: O_byte = {6'b0, cmd_q};
                    default:          O_byte = {data_q[5:0], cmd_q};
                endcase
            end
            ST_B1:   O_byte = (cmd_q == FE_FIFO_CMD_TIME) ? time_q[7:0] : data_q;
            ST_B2:   O_byte = time_q[15:8];
            default: O_byte = 8'h00;
        endcase
    end

`ifdef FE_READER_STATS_EN
    logic [pCOUNT_WIDTH-1:0] bytes_sent_q;
    logic [pCOUNT_WIDTH-1:0] entries_read_q;

    // Flush shares the reset path so a coincident transfer or pop is dropped.
    always_ff @(posedge cwusb_clk) begin
        if (reset_i || I_flush) begin
            bytes_sent_q   <= '0;
            entries_read_q <= '0;
        end else begin
            if (xfer && bytes_sent_q != '1)
                bytes_sent_q <= bytes_sent_q + pCOUNT_WIDTH'(1);
            if (O_fifo_rd && entries_read_q != '1)
                entries_read_q <= entries_read_q + pCOUNT_WIDTH'(1);
        end
    end

    assign O_bytes_sent   = bytes_sent_q;
    assign O_entries_read = entries_read_q;
`else
    assign O_bytes_sent   = '0;
    assign O_entries_read = '0;
`endif

endmodule

// File: tb/tb_fe_fifo_reader.sv
// Directed bench for fe_fifo_reader: a queue models the front-end FIFO and a
// monitor collects every accepted byte for comparison with hand-encoded values.
`timescale 1ns/1ps

module tb_fe_fifo_reader;

`ifdef FE_READER_STATS_EN
    localparam bit STATS = 1'b1;
`else
    localparam bit STATS = 1'b0;
`endif

    localparam logic [1:0] CMD_DATA  = 2'b00;
    localparam logic [1:0] CMD_OTHER = 2'b01;
    localparam logic [1:0] CMD_TIME  = 2'b10;

    typedef struct packed {
        logic [1:0]  cmd;
        logic [15:0] tm;
        logic [7:0]  dat;
    } entry_t;

    logic        cwusb_clk;
    logic        reset_i;
    logic        I_fifo_empty;
    logic        O_fifo_rd;
    logic [1:0]  I_fifo_command;
    logic [15:0] I_fifo_time;
    logic [7:0]  I_fifo_data;
    logic        I_flush;
    logic        I_timestamps_disable;
    logic [7:0]  O_byte;
    logic        O_byte_valid;
    logic        I_byte_ready;
    logic        O_idle;
    logic [23:0] O_bytes_sent;
    logic [23:0] O_entries_read;

    fe_fifo_reader #(.pCOUNT_WIDTH(24)) dut (
        .cwusb_clk           (cwusb_clk),
        .reset_i             (reset_i),
        .I_fifo_empty        (I_fifo_empty),
        .O_fifo_rd           (O_fifo_rd),
        .I_fifo_command      (I_fifo_command),
        .I_fifo_time         (I_fifo_time),
        .I_fifo_data         (I_fifo_data),
        .I_flush             (I_flush),
        .I_timestamps_disable(I_timestamps_disable),
        .O_byte              (O_byte),
        .O_byte_valid        (O_byte_valid),
        .I_byte_ready        (I_byte_ready),
        .O_idle              (O_idle),
        .O_bytes_sent        (O_bytes_sent),
        .O_entries_read      (O_entries_read)
    );

    initial cwusb_clk = 1'b0;
    always #5 cwusb_clk = ~cwusb_clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    int          n_vec  = 0;
    int          n_miss = 0;
    int          cyc, rd_cyc, val_cyc, pops, empty_viol;
    entry_t      fifo_q[$];
    logic [7:0]  out_q[$];
    logic [7:0]  exp_seq[6];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_miss++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // One clock: sample DUT at the falling edge, update the FIFO model after the rising edge.
    task automatic step();
        bit     pop;
        entry_t e;
        @(negedge cwusb_clk);
        cyc++;
        pop = O_fifo_rd;
        if (O_fifo_rd && I_fifo_empty) empty_viol++;
        if (O_fifo_rd && rd_cyc < 0) rd_cyc = cyc;
        if (O_byte_valid && val_cyc < 0) val_cyc = cyc;
        if (O_byte_valid && I_byte_ready) out_q.push_back(O_byte);
        @(posedge cwusb_clk);
        #1;
        if (pop) begin
            pops++;
            if (fifo_q.size() > 0) begin
                e = fifo_q.pop_front();
                I_fifo_command = e.cmd;
                I_fifo_time    = e.tm;
                I_fifo_data    = e.dat;
            end
        end
        I_fifo_empty = (fifo_q.size() == 0);
    endtask

    task automatic run(input int n);
        repeat (n) step();
    endtask

    task automatic clear_mon();
        out_q.delete();
        rd_cyc     = -1;
        val_cyc    = -1;
        pops       = 0;
        empty_viol = 0;
    endtask

    task automatic push(input logic [1:0] cmd, input logic [15:0] tm, input logic [7:0] dat);
        entry_t e;
        e.cmd = cmd;
        e.tm  = tm;
        e.dat = dat;
        fifo_q.push_back(e);
        I_fifo_empty = 1'b0;
    endtask

    task automatic flush_pulse();
        I_flush = 1'b1;
        step();
        I_flush = 1'b0;
    endtask

    task automatic wait_valid(input string tag);
        int k = 0;
        while (!O_byte_valid && k < 20) begin
            step();
            k++;
        end
        check(tag, {31'b0, O_byte_valid}, 32'd1);
    endtask

    initial begin
        reset_i              = 1'b1;
        I_fifo_empty         = 1'b1;
        I_fifo_command       = 2'b00;
        I_fifo_time          = 16'h0;
        I_fifo_data          = 8'h0;
        I_flush              = 1'b0;
        I_timestamps_disable = 1'b0;
        I_byte_ready         = 1'b0;
        cyc                  = 0;
        clear_mon();

        // Reset with a non-empty FIFO: no pop, idle, outputs cleared.
        push(CMD_DATA, 16'h0005, 8'hA7);
        run(2);
        check("rst_rd",      {31'b0, O_fifo_rd},    32'd0);
        check("rst_idle",    {31'b0, O_idle},       32'd1);
        check("rst_valid",   {31'b0, O_byte_valid}, 32'd0);
        check("rst_byte",    {24'b0, O_byte},       32'h00);
        check("rst_bytes",   {8'b0, O_bytes_sent},  32'd0);
        check("rst_entries", {8'b0, O_entries_read}, 32'd0);

        // DATA entry, ready held high.
        reset_i      = 1'b0;
        I_byte_ready = 1'b1;
        clear_mon();
        run(8);
        check("data_len",     out_q.size(), 32'd2);
        check("data_b0",      {24'b0, out_q[0]}, 32'h14);
        check("data_b1",      {24'b0, out_q[1]}, 32'hA7);
        check("data_latency", val_cyc - rd_cyc, 32'd2);
        check("data_pops",    pops, 32'd1);
        check("data_bytes",   {8'b0, O_bytes_sent},   STATS ? 32'd2 : 32'd0);
        check("data_entries", {8'b0, O_entries_read}, STATS ? 32'd1 : 32'd0);

        // TIME entry with timestamps enabled.
        flush_pulse();
        check("flush_bytes",   {8'b0, O_bytes_sent},   32'd0);
        check("flush_entries", {8'b0, O_entries_read}, 32'd0);
        clear_mon();
        push(CMD_TIME, 16'h1234, 8'h00);
        run(8);
        check("time_len",   out_q.size(), 32'd3);
        check("time_b0",    {24'b0, out_q[0]}, 32'h02);
        check("time_b1",    {24'b0, out_q[1]}, 32'h34);
        check("time_b2",    {24'b0, out_q[2]}, 32'h12);
        check("time_bytes", {8'b0, O_bytes_sent}, STATS ? 32'd3 : 32'd0);

        // TIME entry dropped when timestamps are disabled.
        flush_pulse();
        clear_mon();
        I_timestamps_disable = 1'b1;
        push(CMD_TIME, 16'h1234, 8'h00);
        run(6);
        check("tsdis_len",     out_q.size(), 32'd0);
        check("tsdis_pops",    pops, 32'd1);
        check("tsdis_idle",    {31'b0, O_idle}, 32'd1);
        check("tsdis_entries", {8'b0, O_entries_read}, STATS ? 32'd1 : 32'd0);
        check("tsdis_bytes",   {8'b0, O_bytes_sent},   32'd0);
        I_timestamps_disable = 1'b0;

        // Back-pressure during B1 of a DATA entry.
        flush_pulse();
        clear_mon();
        I_byte_ready = 1'b0;
        push(CMD_DATA, 16'h0003, 8'h5C);
        wait_valid("stall_b0_valid");
        check("stall_b0_byte", {24'b0, O_byte}, 32'h0C);
        I_byte_ready = 1'b1;
        step();
        I_byte_ready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            check("stall_hold_valid", {31'b0, O_byte_valid}, 32'd1);
            check("stall_hold_byte",  {24'b0, O_byte},       32'h5C);
            step();
        end
        check("stall_len_held", out_q.size(), 32'd1);
        I_byte_ready = 1'b1;
        step();
        I_byte_ready = 1'b0;
        check("stall_len_done", out_q.size(), 32'd2);
        check("stall_b1",       {24'b0, out_q[1]}, 32'h5C);
        check("stall_idle",     {31'b0, O_idle}, 32'd1);
        run(3);
        check("stall_len_after", out_q.size(), 32'd2);

        // Flush during B1 of a TIME entry, coincident with a transfer.
        flush_pulse();
        clear_mon();
        push(CMD_TIME, 16'hBEEF, 8'h00);
        wait_valid("fl_b0_valid");
        I_byte_ready = 1'b1;
        step();
        check("fl_b1_byte", {24'b0, O_byte}, 32'hEF);
        push(CMD_DATA, 16'h0001, 8'h11);
        I_flush = 1'b1;
        step();
        check("fl_valid",   {31'b0, O_byte_valid},   32'd0);
        check("fl_idle",    {31'b0, O_idle},         32'd1);
        check("fl_bytes",   {8'b0, O_bytes_sent},    32'd0);
        check("fl_entries", {8'b0, O_entries_read},  32'd0);
        pops = 0;
        run(4);
        check("fl_no_pops", pops, 32'd0);
        I_flush = 1'b0;
        run(8);
        check("fl_pops_after", pops, 32'd1);
        check("fl_len",  out_q.size(), 32'd4);
        check("fl_b1",   {24'b0, out_q[1]}, 32'hEF);
        check("fl_next0", {24'b0, out_q[2]}, 32'h04);
        check("fl_next1", {24'b0, out_q[3]}, 32'h11);

        // Three back-to-back entries, then empty.
        flush_pulse();
        clear_mon();
        I_byte_ready = 1'b1;
        push(CMD_DATA,  16'h0021, 8'h99);
        push(CMD_TIME,  16'h00FF, 8'h00);
        push(CMD_OTHER, 16'h0000, 8'h2B);
        exp_seq = '{8'h84, 8'h99, 8'h02, 8'hFF, 8'h00, 8'hAD};
        run(20);
        check("b2b_len", out_q.size(), 32'd6);
        for (int i = 0; i < 6; i++)
            check($sformatf("b2b_byte%0d", i), {24'b0, out_q[i]}, {24'b0, exp_seq[i]});
        check("b2b_pops",       pops, 32'd3);
        check("b2b_empty_rd",   empty_viol, 32'd0);
        check("b2b_entries",    {8'b0, O_entries_read}, STATS ? 32'd3 : 32'd0);
        check("b2b_bytes",      {8'b0, O_bytes_sent},   STATS ? 32'd6 : 32'd0);
        check("b2b_idle",       {31'b0, O_idle}, 32'd1);

`ifdef FE_READER_STATS_EN
        // Saturation of the byte counter.
        flush_pulse();
        force dut.bytes_sent_q = 24'hFFFFFF;
        #1;
        release dut.bytes_sent_q;
        check("sat_preload", {8'b0, O_bytes_sent}, 32'hFFFFFF);
        push(CMD_DATA, 16'h0002, 8'h33);
        run(8);
        check("sat_hold",    {8'b0, O_bytes_sent},   32'hFFFFFF);
        check("sat_entries", {8'b0, O_entries_read}, 32'd1);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule

// File: doc/fe_fifo_reader.md
FE_FIFO_READER -- requirements
Module: fe_fifo_reader

Interface
REQ-001 The block SHALL have parameter pCOUNT_WIDTH, default 24, the width of each statistics counter.
REQ-002 The block SHALL have port cwusb_clk  input  1  the single clock; all logic is on its rising edge.
REQ-003 The block SHALL have port reset_i  input  1  reset, synchronous, active-high.
REQ-004 The block SHALL have port I_fifo_empty  input  1  front-end FIFO empty flag.
REQ-005 The block SHALL have port O_fifo_rd  output  1  FIFO pop; read data is valid the cycle after assertion.
REQ-006 The block SHALL have port I_fifo_command  input  2  popped entry command (FE_FIFO_CMD_* from defines_pw.v).
REQ-007 The block SHALL have port I_fifo_time  input  16  popped entry timestamp.
REQ-008 The block SHALL have port I_fifo_data  input  8  popped entry data.
REQ-009 The block SHALL have port I_flush  input  1  abort and discard.
REQ-010 The block SHALL have port I_timestamps_disable  input  1  drop TIME entries.
REQ-011 The block SHALL have port O_byte  output  8  serialized byte.
REQ-012 The block SHALL have port O_byte_valid  output  1  O_byte is valid.
REQ-013 The block SHALL have port I_byte_ready  input  1  consumer accepts O_byte.
REQ-014 The block SHALL have port O_idle  output  1  FSM is in IDLE.
REQ-015 The block SHALL have port O_bytes_sent  output  pCOUNT_WIDTH  count of accepted bytes.
REQ-016 The block SHALL have port O_entries_read  output  pCOUNT_WIDTH  count of FIFO pops.

Function
REQ-017 The FSM SHALL have states IDLE, LOAD, B0, B1, B2.
- IDLE: O_fifo_rd=1 iff !I_fifo_empty && !I_flush; on pop -> LOAD.
- LOAD: capture command/time/data into registers -> B0.
REQ-018 Byte encoding SHALL be as follows.
- FE_FIFO_CMD_DATA: B0={time[5:0],cmd}, B1=data.
- FE_FIFO_CMD_TIME: B0={6'b0,cmd}, B1=time[7:0], B2=time[15:8].
- Any other command: B0={data[5:0],cmd} only.
REQ-019 Byte transfer SHALL occur on a cycle with O_byte_valid && I_byte_ready; on that cycle the FSM advances to the next byte, or to IDLE after the last byte.
REQ-020 While O_byte_valid=1 and I_byte_ready=0, O_byte and O_byte_valid SHALL be held stable.
REQ-021 O_byte_valid SHALL be asserted in B0/B1/B2 only; latency from O_fifo_rd to first O_byte_valid is exactly 2 cycles.
REQ-022 A TIME entry in LOAD with I_timestamps_disable=1 SHALL be consumed without producing bytes, and the FSM SHALL go LOAD -> IDLE.
REQ-023 I_flush in any state SHALL force IDLE on the next edge, deassert O_byte_valid on the next cycle, and discard any entry popped the previous cycle.
REQ-024 O_fifo_rd SHALL never be asserted while I_fifo_empty=1 or outside IDLE.
REQ-025 O_bytes_sent SHALL increment on each transfer, and O_entries_read SHALL increment on each O_fifo_rd.
REQ-026 Both counters SHALL saturate at all-ones (no wrap) and clear to 0 on I_flush.
REQ-027 A transfer and I_flush on the same cycle SHALL leave the counters cleared (flush wins).

Reset
REQ-028 reset_i SHALL force state IDLE, O_fifo_rd=0, O_byte_valid=0, O_byte=0, O_idle=1, and both counters to 0, on the next rising edge.
REQ-029 reset_i mid-transfer SHALL abandon the current entry without emitting its remaining bytes.

Configuration
REQ-030 Macro FE_READER_STATS_EN SHALL control the statistics counters.
- Defined: REQ-025..027 counters are built.
- Undefined: no counter logic; O_bytes_sent and O_entries_read tied to 0.

Verification
REQ-031 DATA entry (time=5, data=0xA7) with ready held high -> bytes 0x14, 0xA7; O_fifo_rd-to-first-valid = 2 cycles.
REQ-032 TIME entry (time=0x1234), timestamps enabled -> bytes 0x02, 0x34, 0x12; with I_timestamps_disable=1 -> no bytes, O_entries_read=1.
REQ-033 I_byte_ready low for 5 cycles during B1 of a DATA entry -> O_byte held at the data byte with valid high; exactly one transfer when ready rises.
REQ-034 I_flush asserted during B1 of a TIME entry -> O_byte_valid=0 the next cycle, state IDLE, counters 0, no further pops until I_flush is released.
REQ-035 Feed 3 back-to-back entries from a non-empty FIFO, then empty -> no O_fifo_rd while empty, O_entries_read=3, O_bytes_sent equals the sum of the encoded lengths.
REQ-036 With FE_READER_STATS_EN defined, force O_bytes_sent to 2^24-1 and do one more transfer -> stays 0xFFFFFF.
